seg7_scroller: RTL

Display-side stage that sits between the one-second digit counter and the seven-segment output pins. It buffers digit updates in a 4-entry FIFO and shows each buffered digit on the single display for a fixed dwell time, followed by a blank gap, so that fast bursts of counter updates stay readable. It has its own 7-segment decoder and replaces the direct decoder hookup on uo_out[6:0] and uo_out[7].

---
 rtl/seg7_scroller_if.sv | 21 ++
 rtl/seg7_scroller.sv | 125 ++++++++++++
 2 files changed

// File: rtl/seg7_scroller_if.sv
// Digit push strobe and display-side status between counter and scroller.
// The master drives digits; the slave owns the display outputs.
interface seg7_scroller_if;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic [6:0] segments;
    logic       dp;
    logic       busy;
    logic [2:0] level;
    logic       overflow;

    modport master (
        output digit_in, digit_valid,
        input  segments, dp, busy, level, overflow
    );

    modport slave (
        input  digit_in, digit_valid,
        output segments, dp, busy, level, overflow
    );
endinterface

// File: rtl/seg7_scroller.sv
// Buffers digit updates in a 4-deep FIFO and shows each one on a
// single 7-segment display for DWELL cycles followed by BLANK cycles.
module seg7_scroller #(
    parameter logic [23:0] DWELL = 24'd2_500_000,
    parameter logic [23:0] BLANK = 24'd250_000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg7_scroller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [3:0]  r_fifo [4];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [1:0]  w_head_nx;
    logic [2:0]  r_level;
    logic [2:0]  w_level_nx;
    logic [23:0] r_timer;
    logic [6:0]  r_seg;
    logic [6:0]  w_seg_nx;
    logic        r_dp;
    logic        w_dp_nx;
    logic        r_ovf;
    logic        w_pop;
    logic        w_push;
    logic        w_dwell_end;
    logic        w_blank_end;
    logic [3:0]  w_show_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign w_dwell_end = (r_state == SHOW) && (r_timer == DWELL - 24'd1);
    assign w_blank_end = (r_state == GAP) && (r_timer == BLANK - 24'd1);
    assign w_pop       = w_blank_end;
    assign w_push      = bus.digit_valid && ((r_level != 3'd4) || w_pop);
    assign w_level_nx  = r_level - {2'b00, w_pop} + {2'b00, w_push};
    assign w_head_nx   = r_head + 2'd1;

    // Popping the last entry while a push lands: the new head is the
    // slot being written this edge, so take the digit straight from input.
    always_comb begin
        w_show_digit = r_fifo[r_head];
        if (w_pop) begin
            w_show_digit = (r_level == 3'd1) ? bus.digit_in : r_fifo[w_head_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_state_nx != r_state || r_state == IDLE) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 24'd1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (r_level != 3'd0) w_state_nx = SHOW;
            SHOW:    if (w_dwell_end) w_state_nx = GAP;
            GAP:     if (w_blank_end) w_state_nx = (w_level_nx != 3'd0) ? SHOW : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_seg_nx = '0;
        w_dp_nx  = 1'b0;
        if (w_state_nx == SHOW) begin
            w_seg_nx = decode(w_show_digit);
            w_dp_nx  = (w_level_nx == 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_seg   <= '0;
            r_dp    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= bus.digit_in;
                r_tail         <= r_tail + 2'd1;
            end
            if (w_pop) r_head <= w_head_nx;
            if (bus.digit_valid && !w_push) r_ovf <= 1'b1;
            r_level <= w_level_nx;
            r_seg   <= w_seg_nx;
            r_dp    <= w_dp_nx;
        end
    end

    assign bus.segments = r_seg;
    assign bus.dp       = r_dp;
    assign bus.busy     = (r_state != IDLE);
    assign bus.level    = r_level;
    assign bus.overflow = r_ovf;
endmodule
